tc_operand_pipe: RTL and testbench

// - Pipelined, parametrised operand sign-conditioning stage ahead of the Urdhva-Tiryakbhyam vector multiplier array.
// - Converts each signed SIMD lane of an XLEN-bit operand to its unsigned magnitude and reports per-byte sign bits.
// - Adds valid/ready flow control, a 2-stage register pipeline, flush and tag passthrough.
// - Generalises lane widths to 8..XLEN bits.

---
 rtl/tc_pkg.sv | 46 ++++
 rtl/tc_lane_negate.sv | 52 +++++
 rtl/tc_operand_pipe.sv | 143 ++++++++++++++
 tb/tb_tc_operand_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared types and helpers for the two's-complement operand conditioning pipe.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   opcode_e      multiply-type code; decides which operand sides are signed
//   precision_e   lane-size code, lane width = 8 << code
//   lane_lg2()    effective lane-size code after clamping oversize lanes to bytes
//   lane_w()      effective lane width in bits
//   signed_decode() per-side signedness of an opcode
package tc_pkg;

    // MUL/MULH treat both operands as signed, MULHU neither, MULHSU only A.
    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHU  = 2'b10,
        OP_MULHSU = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        PREC_8  = 2'b00,
        PREC_16 = 2'b01,
        PREC_32 = 2'b10,
        PREC_64 = 2'b11
    } precision_e;

    // A lane code wider than the operand falls back to byte lanes, which keeps
    // the legacy XLEN=32 behaviour of code 11 meaning 8-bit lanes.
    function automatic logic [1:0] lane_lg2(input logic [1:0] prec, input int unsigned xlen);
        return ((32'd8 << prec) > xlen) ? 2'd0 : prec;
    endfunction

    function automatic int unsigned lane_w(input logic [1:0] prec, input int unsigned xlen);
        return 32'd8 << lane_lg2(prec, xlen);
    endfunction

    // operand_b selects the B-side decode (MULHSU leaves B unsigned).
    function automatic logic signed_decode(input opcode_e op, input logic operand_b);
        if (operand_b)
            return (op == OP_MUL) || (op == OP_MULH);
        else
            return (op != OP_MULHU);
    endfunction

endpackage

// File: rtl/tc_lane_negate.sv
// Byte-segmented conditional negation: each byte flagged in neg is inverted and
// the +1 ripples only within its lane. Latency: combinational. Backpressure: none.
//
// Ports:
//   operand    [XLEN-1:0]   raw operand
//   precision  [1:0]        lane-size code (clamped to byte lanes if oversize)
//   neg        [XLEN/8-1:0] per-byte negate enable; all bytes of a lane agree
//   magnitude  [XLEN-1:0]   lane-wise result: -lane where negated, else raw
module tc_lane_negate
    import tc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]   operand,
    input  logic [1:0]        precision,
    input  logic [XLEN/8-1:0] neg,
    output logic [XLEN-1:0]   magnitude
);

    localparam int unsigned NBYTES = XLEN / 8;

    logic [1:0]        lg2;
    // carry[i] is the carry arriving at byte i from byte i-1.
    logic [NBYTES-1:0] carry;

    assign lg2      = lane_lg2(precision, XLEN);
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        // Whether byte i opens a lane, for each possible lane size.
        localparam bit START_16 = (i % 2) == 0;
        localparam bit START_32 = (i % 4) == 0;
        localparam bit START_64 = (i % 8) == 0;

        logic [3:0] start_sel;
        logic       cin;
        logic [7:0] inv;

        assign start_sel = {START_64, START_32, START_16, 1'b1};
        // The +1 of the two's complement enters at the lane's lowest byte;
        // higher bytes only take the ripple, so nothing crosses a lane edge.
        assign cin = start_sel[lg2] ? neg[i] : carry[i];
        assign inv = operand[8*i +: 8] ^ {8{neg[i]}};
        assign magnitude[8*i +: 8] = inv + {7'd0, cin};

        // Adding a single bit carries out only when the byte is all ones.
        if (i < NBYTES - 1) begin : g_carry
            assign carry[i+1] = cin & (&inv);
        end
    end

endmodule

// File: rtl/tc_operand_pipe.sv
// Two-stage valid/ready pipe turning signed SIMD lanes into unsigned magnitudes plus per-byte sign mask.
// Latency: 2 cycles in_valid->out_valid, throughput 1 entry/cycle.
// Backpressure: out_ready low stalls S2 then S1; in_ready is combinational from out_ready (no skid buffer).
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   flush                synchronous clear of all in-flight entries
//   in_valid/in_ready    input handshake; opcode, precision, operand, in_tag ride with it
//   out_valid/out_ready  output handshake; operand_tc, sign_mask, out_tag ride with it
//   operand_tc           per-lane magnitude, zero when out_valid is low
//   sign_mask            one bit per byte, set for every byte of a negated lane
//   out_tag              sideband tag of the output entry
module tc_operand_pipe
    import tc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned OPERAND_B = 0,
    parameter int unsigned TAG_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        opcode,
    input  logic [1:0]        precision,
    input  logic [XLEN-1:0]   operand,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   operand_tc,
    output logic [XLEN/8-1:0] sign_mask,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned NBYTES = XLEN / 8;

    // Stage 1: raw entry as accepted.
    logic              s1_valid;
    logic [1:0]        s1_opcode;
    logic [1:0]        s1_precision;
    logic [XLEN-1:0]   s1_operand;
    logic [TAG_W-1:0]  s1_tag;

    // Stage 2: conditioned result.
    logic              s2_valid;
    logic [XLEN-1:0]   s2_operand_tc;
    logic [NBYTES-1:0] s2_sign_mask;
    logic [TAG_W-1:0]  s2_tag;

    logic              s2_advance;
    logic              s1_advance;
    logic              in_fire;

    logic [1:0]        s1_lg2;
    logic              s1_signed;
    logic [NBYTES-1:0] s1_neg;
    logic [XLEN-1:0]   s1_magnitude;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    assign s2_advance = !s2_valid || out_ready;
    // S1 moves whenever S2 can take it; an empty S1 is always free.
    assign s1_advance = s2_advance;
    assign in_ready   = !s1_valid || s1_advance;
    assign in_fire    = in_valid && in_ready;

    // Only the valid bits are reset; flush drops everything, including an
    // entry offered in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_advance)
                s2_valid <= s1_valid;
            if (in_ready)
                s1_valid <= in_valid;
        end
    end

    // Data registers carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_opcode    <= opcode;
            s1_precision <= precision;
            s1_operand   <= operand;
            s1_tag       <= in_tag;
        end
        if (s1_advance && s1_valid) begin
            s2_operand_tc <= s1_magnitude;
            s2_sign_mask  <= s1_neg;
            s2_tag        <= s1_tag;
        end
    end

    // ------------------------------------------------------------------
    // Per-byte negate mask: a byte is negated when its lane is signed and
    // the lane's top bit is set. Every byte looks at the MSB of the most
    // significant byte of its own lane, so all bytes of a lane agree.
    // ------------------------------------------------------------------
    assign s1_lg2    = lane_lg2(s1_precision, XLEN);
    assign s1_signed = signed_decode(opcode_e'(s1_opcode), OPERAND_B != 0);

    for (genvar i = 0; i < NBYTES; i++) begin : g_neg
        // Bit index of the lane MSB for each lane size; sizes that do not
        // fit the operand are never selected, so point them at this byte.
        localparam int unsigned MSB_8  = 8*i + 7;
        localparam int unsigned MSB_16 = (XLEN >= 16) ? 8*(i | 1) + 7 : MSB_8;
        localparam int unsigned MSB_32 = (XLEN >= 32) ? 8*(i | 3) + 7 : MSB_8;
        localparam int unsigned MSB_64 = (XLEN >= 64) ? 8*(i | 7) + 7 : MSB_8;

        logic [3:0] msb_sel;

        assign msb_sel   = {s1_operand[MSB_64], s1_operand[MSB_32],
                            s1_operand[MSB_16], s1_operand[MSB_8]};
        assign s1_neg[i] = s1_signed & msb_sel[s1_lg2];
    end

    // The most negative lane value maps onto itself, which is already the
    // correct unsigned magnitude, so no overflow handling is needed.
    tc_lane_negate #(
        .XLEN (XLEN)
    ) u_lane_negate (
        .operand   (s1_operand),
        .precision (s1_precision),
        .neg       (s1_neg),
        .magnitude (s1_magnitude)
    );

    // ------------------------------------------------------------------
    // Outputs read as zero while nothing is presented.
    // ------------------------------------------------------------------
    assign out_valid  = s2_valid;
    assign operand_tc = s2_valid ? s2_operand_tc : '0;
    assign sign_mask  = s2_valid ? s2_sign_mask  : '0;
    assign out_tag    = s2_valid ? s2_tag        : '0;

endmodule

// File: tb/tb_tc_operand_pipe.sv
module tb_tc_operand_pipe;

    typedef struct packed {
        logic [127:0] tc;
        logic [15:0]  sm;
        logic [3:0]   tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [1:0]  opcode;
    logic [1:0]  precision;
    logic [31:0] op32;
    logic [63:0] op64;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [31:0] tc0, tc1;
    logic [63:0] tc2;
    logic [3:0]  sm0, sm1;
    logic [7:0]  sm2;
    logic [3:0]  tag0, tag1, tag2;

    int   n_vec = 0;
    int   n_err = 0;
    int   stalls = 0;
    bit   rdy_force = 1'b1;
    logic rdy_val = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // A-side 32-bit, B-side 32-bit, A-side 64-bit; all share one handshake.
    tc_operand_pipe #(.XLEN(32), .OPERAND_B(0), .TAG_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .opcode(opcode), .precision(precision), .operand(op32), .in_tag(in_tag),
        .out_valid(ov0), .out_ready(out_ready), .operand_tc(tc0), .sign_mask(sm0), .out_tag(tag0));

    tc_operand_pipe #(.XLEN(32), .OPERAND_B(1), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .opcode(opcode), .precision(precision), .operand(op32), .in_tag(in_tag),
        .out_valid(ov1), .out_ready(out_ready), .operand_tc(tc1), .sign_mask(sm1), .out_tag(tag1));

    tc_operand_pipe #(.XLEN(64), .OPERAND_B(0), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
        .opcode(opcode), .precision(precision), .operand(op64), .in_tag(in_tag),
        .out_valid(ov2), .out_ready(out_ready), .operand_tc(tc2), .sign_mask(sm2), .out_tag(tag2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Consumer ready: random unless the main sequence pins it.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_force) out_ready = rdy_val;
            else           out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference: treat each lane as an integer; a negative signed lane is
    // replaced by 2^W - value, which is its magnitude modulo 2^W.
    function automatic exp_t model(input logic [127:0] d, input int xlen, input bit ob,
                                   input logic [1:0] opc, input logic [1:0] prec,
                                   input logic [3:0] tag);
        exp_t         e;
        int           w;
        bit           sgn;
        bit           neg;
        logic [127:0] mask;
        logic [127:0] lane;
        logic [127:0] mag;
        w = 8 << prec;
        if (w > xlen) w = 8;
        sgn  = ob ? (opc <= 2'd1) : (opc != 2'd2);
        mask = (128'd1 << w) - 128'd1;
        e    = '0;
        for (int j = 0; j < xlen / w; j++) begin
            lane = (d >> (j * w)) & mask;
            neg  = sgn && (((lane >> (w - 1)) & 128'd1) != 128'd0);
            mag  = neg ? (((128'd1 << w) - lane) & mask) : lane;
            e.tc = e.tc | (mag << (j * w));
            if (neg)
                for (int b = 0; b < w / 8; b++) e.sm[j * (w / 8) + b] = 1'b1;
        end
        e.tag = tag;
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic [127:0] tc, input logic [15:0] sm, input logic [3:0] tag);
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        n_vec++;
        if (!have) begin
            n_err++;
            $display("FAIL out_unexpected dut%0d: got tc=%0h sm=%0h tag=%0h with nothing expected", k, tc, sm, tag);
        end else if (tc !== e.tc || sm !== e.sm || tag !== e.tag) begin
            n_err++;
            $display("FAIL out_data dut%0d: got tc=%0h sm=%0h tag=%0h expected tc=%0h sm=%0h tag=%0h",
                     k, tc, sm, tag, e.tc, e.sm, e.tag);
        end
    endtask

    // Monitor: an output is consumed on a cycle with out_valid & out_ready.
    always @(negedge clk) begin
        if (!rst && out_ready) begin
            if (ov0) mon(0, {96'd0, tc0}, {12'd0, sm0}, tag0);
            if (ov1) mon(1, {96'd0, tc1}, {12'd0, sm1}, tag1);
            if (ov2) mon(2, {64'd0, tc2}, {8'd0, sm2}, tag2);
        end
    end

    task automatic set_ready(input logic v);
        rdy_force = 1'b1;
        rdy_val   = v;
        out_ready = v;
    endtask

    task automatic clear_q();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] opc, input logic [1:0] prec, input logic [31:0] d32,
                        input logic [63:0] d64, input logic [3:0] tag);
        int waited;
        waited    = 0;
        in_valid  = 1'b1;
        opcode    = opc;
        precision = prec;
        op32      = d32;
        op64      = d64;
        in_tag    = tag;
        @(negedge clk);
        while (!ir0 && waited < 50) begin
            stalls++;
            waited++;
            @(negedge clk);
        end
        if (!ir0) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", ir0, waited);
        end else if (!flush && !rst) begin
            q0.push_back(model({96'd0, d32}, 32, 1'b0, opc, prec, tag));
            q1.push_back(model({96'd0, d32}, 32, 1'b1, opc, prec, tag));
            q2.push_back(model({64'd0, d64}, 64, 1'b0, opc, prec, tag));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send, then step to the cycle the entry must be presented.
    task automatic dir(input logic [1:0] opc, input logic [1:0] prec, input logic [31:0] d32,
                       input logic [63:0] d64, input logic [3:0] tag);
        send(opc, prec, d32, d64, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_pending", 128'(q0.size() + q1.size() + q2.size()), 128'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        opcode = 2'd0; precision = 2'd0; op32 = '0; op64 = '0; in_tag = '0;
        set_ready(1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 128'(ov0), 128'd0);
        chk("rst_in_ready",  128'(ir0), 128'd1);
        chk("rst_operand_tc", 128'(tc0), 128'd0);
        chk("rst_sign_mask", 128'(sm0), 128'd0);
        chk("rst_out_tag",   128'(tag0), 128'd0);

        // Directed lane vectors, two-cycle latency
        set_ready(1'b1);
        send(2'b00, 2'b00, 32'h80FF_7F01, 64'h0, 4'h1);
        chk("lat_not_yet", 128'(ov0), 128'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", 128'(ov0), 128'd1);
        chk("b8_tc", 128'(tc0), 128'h8001_7F01);
        chk("b8_sm", 128'(sm0), 128'hC);
        chk("b8_tag", 128'(tag0), 128'h1);
        chk("b8_tc_bside", 128'(tc1), 128'h8001_7F01);

        dir(2'b00, 2'b01, 32'hFFFE_0005, 64'h0, 4'h2);
        chk("h16_tc", 128'(tc0), 128'h0002_0005);
        chk("h16_sm", 128'(sm0), 128'hC);

        dir(2'b00, 2'b10, 32'hFFFF_FFFF, 64'h0, 4'h3);
        chk("w32_tc", 128'(tc0), 128'h0000_0001);
        chk("w32_sm", 128'(sm0), 128'hF);

        dir(2'b11, 2'b00, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h4);
        chk("su_bside_tc", 128'(tc1), 128'hFFFF_FFFF);
        chk("su_bside_sm", 128'(sm1), 128'h0);
        chk("su_aside_tc", 128'(tc0), 128'h0101_0101);
        chk("su_aside_sm", 128'(sm0), 128'hF);
        chk("su_x64_tc", 128'(tc2), 128'h0101_0101_0101_0101);

        dir(2'b00, 2'b11, 32'h8000_0000, 64'h8000_0000_0000_0000, 4'h5);
        chk("d64_tc", 128'(tc2), 128'h8000_0000_0000_0000);
        chk("d64_sm", 128'(sm2), 128'hFF);
        chk("d64_on32_tc", 128'(tc0), 128'h8000_0000);
        chk("d64_on32_sm", 128'(sm0), 128'h8);
        drain();

        // Back-to-back 8 entries with a three-cycle consumer stall
        stalls = 0;
        fork
            begin
                for (int n = 0; n < 8; n++)
                    send(2'($urandom), 2'($urandom), $urandom, {$urandom, $urandom}, 4'(n));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                set_ready(1'b0);
                repeat (3) @(posedge clk);
                #1;
                set_ready(1'b1);
            end
        join
        chk("b2b_in_ready_dropped", 128'(stalls > 0), 128'd1);
        drain();

        // Flush with both stages full
        set_ready(1'b0);
        send(2'b00, 2'b00, 32'h8181_8181, 64'h1, 4'h6);
        send(2'b00, 2'b00, 32'h8282_8282, 64'h2, 4'h7);
        chk("full_in_ready", 128'(ir0), 128'd0);
        flush = 1'b1;
        clear_q();
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_out_valid", 128'(ov0), 128'd0);
        chk("flush_in_ready", 128'(ir0), 128'd1);

        // An entry offered during flush is dropped
        flush = 1'b1;
        send(2'b00, 2'b00, 32'hDEAD_BEEF, 64'h3, 4'h8);
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_drop_in", 128'(ov0), 128'd0);
        set_ready(1'b1);
        dir(2'b10, 2'b00, 32'h1234_5678, 64'h4, 4'h9);
        chk("post_flush_valid", 128'(ov0), 128'd1);
        chk("post_flush_tag", 128'(tag0), 128'h9);
        drain();

        // Reset mid-operation
        set_ready(1'b0);
        send(2'b00, 2'b01, 32'h8000_8000, 64'h5, 4'hA);
        send(2'b00, 2'b01, 32'h7FFF_8001, 64'h6, 4'hB);
        rst = 1'b1;
        clear_q();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 128'(ov0), 128'd0);
        chk("midrst_in_ready", 128'(ir0), 128'd1);
        chk("midrst_tc", 128'(tc0), 128'd0);
        chk("midrst_tag", 128'(tag0), 128'd0);
        set_ready(1'b1);
        dir(2'b01, 2'b01, 32'h8000_FFFF, 64'h7, 4'hC);
        chk("post_rst_valid", 128'(ov0), 128'd1);
        chk("post_rst_tc", 128'(tc0), 128'h8000_0001);
        drain();

        // Random traffic with random consumer backpressure
        rdy_force = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                send(2'($urandom), 2'($urandom), $urandom, {$urandom, $urandom}, 4'($urandom));
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
